fxp_add_arbiter: RTL

Round-robin arbiter and sequencer that shares one unsigned fixed-point adder (INT_W integer bits, FRAC_W fractional bits) between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes the sum in its single adder datapath, and returns the result through a one-entry output register tagged with the requester ID. It sits between the fixed-point producers and any downstream consumer that needs serialized sums.

---
 rtl/fxp_add_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/fxp_add_arbiter.sv
// Round-robin arbiter sharing one unsigned fixed-point adder between NREQ requesters.
// Results leave through a one-entry register tagged with the requester ID.
module fxp_add_arbiter #(
   parameter  int unsigned NREQ   = 4,
   parameter  int unsigned INT_W  = 8,
   parameter  int unsigned FRAC_W = 4,
   localparam int unsigned IDW    = $clog2(NREQ),
   localparam int unsigned OPW    = INT_W + FRAC_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*OPW-1:0] req_a,
   input  logic [NREQ*OPW-1:0] req_b,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [INT_W:0]      res_int,
   output logic [FRAC_W-1:0]   res_frac,
   output logic [IDW-1:0]      res_id,
   output logic                res_ovf,
   output logic [15:0]         busy_cnt
);

   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] gnt_idx, cand;
   logic           gnt_found;
   logic           slot_free, accept, drain;
   logic [OPW-1:0] a_sel, b_sel;
   logic [OPW:0]   sum;
   logic [OPW:0]   res_q, res_d;
   logic [IDW-1:0] id_q, id_d;
   logic           valid_q, valid_d;
   logic [15:0]    cnt_q, cnt_d;

   // Search from ptr upward; IDW-bit addition wraps modulo NREQ since NREQ is a power of two.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = ptr_q + IDW'(k);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            a_sel = req_a[i*OPW +: OPW];
            b_sel = req_b[i*OPW +: OPW];
         end
      end
      sum = {1'b0, a_sel} + {1'b0, b_sel};
   end

   always_comb begin
      slot_free = !valid_q || res_ready;
      accept    = gnt_found && slot_free;
      drain     = valid_q && res_ready;
      req_ready = '0;
      // Reset gating keeps req_ready low for the whole time rst_n is asserted.
      if (accept && rst_n) begin
         req_ready[gnt_idx] = 1'b1;
      end

      valid_d = valid_q;
      res_d   = res_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      if (accept) begin
         valid_d = 1'b1;
         res_d   = sum;
         id_d    = gnt_idx;
         ptr_d   = gnt_idx + IDW'(1);
      end else if (drain) begin
         valid_d = 1'b0;
      end

      cnt_d = cnt_q;
      if (drain && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         valid_q <= 1'b0;
         res_q   <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         res_q   <= res_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
      end
   end

   assign res_valid = valid_q;
   assign res_int   = res_q[OPW:FRAC_W];
   assign res_frac  = res_q[FRAC_W-1:0];
   assign res_id    = id_q;
   assign res_ovf   = res_q[OPW];
   assign busy_cnt  = cnt_q;

endmodule
